sim_run_ctrl: RTL and testbench

Parametrised simulation run-control block for the test-bench tops. It sequences the DUT reset and keeps the cycle and event counters. It runs a per-channel activity watchdog over NCH channels and enforces a global cycle budget. It ends the run with a one-cycle `finish_o` pulse and a sticky pass/fail verdict that the enclosing top turns into `$finish` and status reporting.

---
 rtl/sim_run_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sim_run_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run-control block for simulation tops.
// Sequences the DUT reset, counts cycles and channel events, runs a per-channel
// idle watchdog plus a global cycle budget, and ends the run with a one-cycle
// finish pulse followed by a sticky pass/fail verdict.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   event_i      per-channel activity strobe
//   done_i       per-channel completion (latched internally)
//   reset_n_o    active-low reset to the DUT
//   clk_cnt_o    cycles since rst_i deasserted (frozen once the run ends)
//   event_cnt_o  saturating count of event_i bits seen in RUN
//   state_o      HOLD=0, RUN=1, PASS=2, FAIL=3
//   finish_o     one-cycle pulse on entry to PASS or FAIL
//   pass_o       sticky pass verdict
//   fail_o       sticky fail verdict
//   fail_ch_o    sticky mask of timed-out channels
//   budget_to_o  sticky global budget exhausted flag
module sim_run_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned NCH          = 4,
    parameter int unsigned RESET_CYCLES = 11,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned TIMEOUT      = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NCH-1:0]   event_i,
    input  logic [NCH-1:0]   done_i,
    output logic             reset_n_o,
    output logic [CNT_W-1:0] clk_cnt_o,
    output logic [63:0]      event_cnt_o,
    output logic [1:0]       state_o,
    output logic             finish_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [NCH-1:0]   fail_ch_o,
    output logic             budget_to_o
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT);
    localparam int unsigned PC_W   = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              finish_nxt;
    logic              budget_nxt;

    logic [IDLE_W-1:0] idle_cnt [NCH];
    logic [NCH-1:0]    done_lat;
    logic [NCH-1:0]    ch_fail;
    logic              all_done;
    logic              budget_hit;
    logic [PC_W-1:0]   pc;
    logic [64:0]       ev_sum;
    logic [63:0]       ev_cnt_nxt;

    // Per-channel watchdog: idle counter at its limit with no activity this cycle.
    always_comb begin
        ch_fail = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            ch_fail[c] = (state == S_RUN) && (idle_cnt[c] == IDLE_W'(TIMEOUT - 1))
                         && !event_i[c] && !done_i[c] && !done_lat[c];
        end
    end

    assign all_done   = &(done_lat | done_i);
    assign budget_hit = (clk_cnt_o == CNT_W'(MAX_CYCLES - 1));

    // Saturating event accumulator input.
    always_comb begin
        pc = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            pc = pc + PC_W'(event_i[i]);
        end
        ev_sum     = {1'b0, event_cnt_o} + 65'(pc);
        ev_cnt_nxt = ev_sum[64] ? '1 : ev_sum[63:0];
    end

    // Next state; channel failure outranks completion, which outranks the budget.
    always_comb begin
        state_nxt  = state;
        finish_nxt = 1'b0;
        budget_nxt = 1'b0;
        case (state)
            S_HOLD: begin
                if (clk_cnt_o == CNT_W'(RESET_CYCLES - 1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (|ch_fail) begin
                    state_nxt  = S_FAIL;
                    finish_nxt = 1'b1;
                end else if (all_done) begin
                    state_nxt  = S_PASS;
                    finish_nxt = 1'b1;
                end else if (budget_hit) begin
                    state_nxt  = S_FAIL;
                    finish_nxt = 1'b1;
                    budget_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, watchdog state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reset_n_o   <= 1'b0;
            clk_cnt_o   <= '0;
            event_cnt_o <= '0;
            finish_o    <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_ch_o   <= '0;
            budget_to_o <= 1'b0;
            done_lat    <= '0;
            for (int c = 0; c < int'(NCH); c++) begin
                idle_cnt[c] <= '0;
            end
        end else begin
            finish_o  <= finish_nxt;
            reset_n_o <= (state_nxt != S_HOLD);
            if (state == S_HOLD || state == S_RUN) begin
                clk_cnt_o <= clk_cnt_o + CNT_W'(1);
            end
            if (state == S_RUN) begin
                done_lat    <= done_lat | done_i;
                event_cnt_o <= ev_cnt_nxt;
                fail_ch_o   <= fail_ch_o | ch_fail;
                if (budget_nxt) begin
                    budget_to_o <= 1'b1;
                end
                for (int c = 0; c < int'(NCH); c++) begin
                    if (event_i[c] || done_i[c] || done_lat[c]) begin
                        idle_cnt[c] <= '0;
                    end else begin
                        idle_cnt[c] <= idle_cnt[c] + IDLE_W'(1);
                    end
                end
            end
            // Verdict follows the finish pulse by one cycle.
            if (state == S_PASS) begin
                pass_o <= 1'b1;
            end
            if (state == S_FAIL) begin
                fail_o <= 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: self-checking bench for sim_run_ctrl.
// Directed scenario table, hand-written reset sequences, and randomized traces
// checked against a timestamp-based model of the run rules.
module tb_sim_run_ctrl;

    localparam int CNT_W = 32;
    localparam int NCH   = 4;
    localparam int RC    = 11;
    localparam int MAXC  = 1000;
    localparam int TO    = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [NCH-1:0]   event_i;
    logic [NCH-1:0]   done_i;
    logic             reset_n_o;
    logic [CNT_W-1:0] clk_cnt_o;
    logic [63:0]      event_cnt_o;
    logic [1:0]       state_o;
    logic             finish_o;
    logic             pass_o;
    logic             fail_o;
    logic [NCH-1:0]   fail_ch_o;
    logic             budget_to_o;

    always #5 clk_i = ~clk_i;

    sim_run_ctrl #(
        .CNT_W(CNT_W), .NCH(NCH), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .event_i(event_i), .done_i(done_i),
        .reset_n_o(reset_n_o), .clk_cnt_o(clk_cnt_o), .event_cnt_o(event_cnt_o),
        .state_o(state_o), .finish_o(finish_o), .pass_o(pass_o), .fail_o(fail_o),
        .fail_ch_o(fail_ch_o), .budget_to_o(budget_to_o)
    );

    typedef struct {
        int             period;
        logic [NCH-1:0] ev_mask;
        int             d0_t;
        logic [NCH-1:0] d0_m;
        int             d1_t;
        logic [NCH-1:0] d1_m;
        int             exp_t;
        int             exp_st;
        logic [63:0]    exp_evc;
        logic [NCH-1:0] exp_fch;
        logic           exp_bud;
    } vec_t;

    int             n_checks = 0;
    int             n_err    = 0;
    logic [NCH-1:0] ev_tr [MAXC];
    logic [NCH-1:0] dn_tr [MAXC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reset edge with junk on the inputs; everything must read back zero.
    task automatic apply_reset();
        rst_i   = 1'b1;
        event_i = NCH'($urandom);
        done_i  = NCH'($urandom);
        @(posedge clk_i);
        #1;
        chk("rst reset_n", 64'(reset_n_o), 0);
        chk("rst clk_cnt", 64'(clk_cnt_o), 0);
        chk("rst event_cnt", event_cnt_o, 0);
        chk("rst state", 64'(state_o), 0);
        chk("rst finish", 64'(finish_o), 0);
        chk("rst pass", 64'(pass_o), 0);
        chk("rst fail", 64'(fail_o), 0);
        chk("rst fail_ch", 64'(fail_ch_o), 0);
        chk("rst budget", 64'(budget_to_o), 0);
        rst_i   = 1'b0;
        event_i = '0;
        done_i  = '0;
    endtask

    // Drive cycles 0..n-1 from the trace, checking the pre-verdict outputs each cycle.
    task automatic run_prefix(input int n);
        for (int k = 0; k < n; k++) begin
            event_i = ev_tr[k];
            done_i  = dn_tr[k];
            chk("cyc clk_cnt", 64'(clk_cnt_o), 64'(k));
            chk("cyc reset_n", 64'(reset_n_o), 64'(k >= RC));
            chk("cyc state", 64'(state_o), (k >= RC) ? 64'd1 : 64'd0);
            chk("cyc finish", 64'(finish_o), 0);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic run_trace(input int t_end, input int st, input logic [63:0] evc,
                             input logic [NCH-1:0] fch, input logic bud);
        run_prefix(t_end + 1);
        chk("end finish", 64'(finish_o), 1);
        chk("end state", 64'(state_o), 64'(st));
        chk("end clk_cnt", 64'(clk_cnt_o), 64'(t_end + 1));
        chk("end event_cnt", event_cnt_o, evc);
        chk("end fail_ch", 64'(fail_ch_o), 64'(fch));
        chk("end budget", 64'(budget_to_o), 64'(bud));
        chk("end pass early", 64'(pass_o), 0);
        chk("end fail early", 64'(fail_o), 0);
        chk("end reset_n", 64'(reset_n_o), 1);
        // Activity after the verdict must not be counted or change anything.
        event_i = '1;
        done_i  = NCH'($urandom);
        @(posedge clk_i);
        #1;
        chk("post finish", 64'(finish_o), 0);
        chk("post pass", 64'(pass_o), 64'(st == 2));
        chk("post fail", 64'(fail_o), 64'(st == 3));
        chk("post state", 64'(state_o), 64'(st));
        chk("post clk_cnt", 64'(clk_cnt_o), 64'(t_end + 1));
        chk("post event_cnt", event_cnt_o, evc);
        chk("post fail_ch", 64'(fail_ch_o), 64'(fch));
        chk("post budget", 64'(budget_to_o), 64'(bud));
        @(posedge clk_i);
        #1;
        chk("post2 finish", 64'(finish_o), 0);
        chk("post2 pass", 64'(pass_o), 64'(st == 2));
        event_i = '0;
        done_i  = '0;
    endtask

    task automatic fill_pattern(input int period, input logic [NCH-1:0] mask,
                                input int d0t, input logic [NCH-1:0] d0m,
                                input int d1t, input logic [NCH-1:0] d1m);
        for (int k = 0; k < MAXC; k++) begin
            ev_tr[k] = (k >= RC && ((k - RC) % period) == 0) ? mask : '0;
            dn_tr[k] = ((k == d0t) ? d0m : '0) | ((k == d1t) ? d1m : '0);
        end
    endtask

    task automatic fill_random();
        int pct [NCH];
        int dt  [NCH];
        for (int c = 0; c < NCH; c++) begin
            case ($urandom_range(0, 3))
                0:       pct[c] = 3;
                1:       pct[c] = 15;
                2:       pct[c] = 40;
                default: pct[c] = 80;
            endcase
            dt[c] = ($urandom_range(0, 4) == 0) ? -1 : RC + int'($urandom_range(0, 250));
        end
        for (int k = 0; k < MAXC; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (k < RC) begin
                    ev_tr[k][c] = 1'($urandom);
                    dn_tr[k][c] = 1'($urandom);
                end else begin
                    ev_tr[k][c] = (int'($urandom_range(0, 99)) < pct[c]);
                    dn_tr[k][c] = (k == dt[c]);
                end
            end
        end
    endtask

    // Reference: a channel's idle stretch starts after its last event (or run start);
    // it fails when the stretch reaches TO cycles with no event or done on that cycle.
    task automatic model(output int t_end, output int st, output logic [63:0] evc,
                         output logic [NCH-1:0] fch, output logic bud);
        int             start [NCH];
        logic [NCH-1:0] lat;
        logic [NCH-1:0] fm;
        lat   = '0;
        evc   = '0;
        fch   = '0;
        bud   = 1'b0;
        st    = 3;
        t_end = MAXC - 1;
        for (int c = 0; c < NCH; c++) start[c] = RC;
        for (int k = RC; k < MAXC; k++) begin
            fm = '0;
            for (int c = 0; c < NCH; c++) begin
                if (!lat[c] && !dn_tr[k][c] && !ev_tr[k][c] && (k - start[c]) == TO - 1)
                    fm[c] = 1'b1;
            end
            lat = lat | dn_tr[k];
            evc = evc + 64'($countones(ev_tr[k]));
            for (int c = 0; c < NCH; c++) begin
                if (ev_tr[k][c] || lat[c]) start[c] = k + 1;
            end
            if (fm != '0) begin
                t_end = k; st = 3; fch = fm;
                return;
            end
            if (&lat) begin
                t_end = k; st = 2;
                return;
            end
            if (k == MAXC - 1) begin
                t_end = k; st = 3; bud = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        vec_t           tbl [9];
        int             m_t;
        int             m_st;
        logic [63:0]    m_evc;
        logic [NCH-1:0] m_fch;
        logic           m_bud;

        rst_i   = 1'b1;
        event_i = '0;
        done_i  = '0;

        //            per mask     d0_t d0_m     d1_t d1_m     T    st evc  fch      bud
        tbl[0] = '{8,  4'b1111, 60,  4'b1111, -1,  4'b0000, 60,  2, 28,  4'b0000, 1'b0};
        tbl[1] = '{8,  4'b1011, -1,  4'b0000, -1,  4'b0000, 26,  3, 6,   4'b0100, 1'b0};
        tbl[2] = '{4,  4'b1111, -1,  4'b0000, -1,  4'b0000, 999, 3, 992, 4'b0000, 1'b1};
        tbl[3] = '{8,  4'b1011, 20,  4'b0011, 26,  4'b1000, 26,  3, 6,   4'b0100, 1'b0};
        tbl[4] = '{8,  4'b1111, 11,  4'b1111, -1,  4'b0000, 11,  2, 4,   4'b0000, 1'b0};
        tbl[5] = '{8,  4'b1111, 15,  4'b0001, 40,  4'b1110, 40,  2, 16,  4'b0000, 1'b0};
        tbl[6] = '{16, 4'b1111, 100, 4'b1111, -1,  4'b0000, 100, 2, 24,  4'b0000, 1'b0};
        tbl[7] = '{17, 4'b1111, -1,  4'b0000, -1,  4'b0000, 27,  3, 4,   4'b1111, 1'b0};
        tbl[8] = '{8,  4'b1011, 26,  4'b0100, 30,  4'b1011, 30,  2, 9,   4'b0000, 1'b0};

        for (int i = 0; i < 9; i++) begin
            apply_reset();
            fill_pattern(tbl[i].period, tbl[i].ev_mask, tbl[i].d0_t, tbl[i].d0_m,
                         tbl[i].d1_t, tbl[i].d1_m);
            run_trace(tbl[i].exp_t, tbl[i].exp_st, tbl[i].exp_evc, tbl[i].exp_fch,
                      tbl[i].exp_bud);
        end

        // Reset in the middle of RUN, then a full replay of the passing run.
        apply_reset();
        fill_pattern(8, 4'b1111, 60, 4'b1111, -1, 4'b0000);
        run_prefix(40);
        chk("mid clk_cnt", 64'(clk_cnt_o), 40);
        apply_reset();
        run_trace(60, 2, 28, 4'b0000, 1'b0);

        // Reset from the terminal FAIL state, then replay the reset sequence.
        apply_reset();
        fill_pattern(8, 4'b1011, -1, 4'b0000, -1, 4'b0000);
        run_trace(26, 3, 6, 4'b0100, 1'b0);
        apply_reset();
        fill_pattern(8, 4'b1011, -1, 4'b0000, -1, 4'b0000);
        run_prefix(RC + 2);

        // Randomized traces against the reference model.
        for (int r = 0; r < 12; r++) begin
            apply_reset();
            fill_random();
            model(m_t, m_st, m_evc, m_fch, m_bud);
            run_trace(m_t, m_st, m_evc, m_fch, m_bud);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
